// File: rtl/sc_regshifter_exec.sv
// Datapath end of the register-shifter control interface: executes clear, load and
// shift commands exactly once per assertion and reports carry, zero, count and errors.
module sc_regshifter_exec #(
  parameter int DATAWIDTH  = 8,
  parameter int COUNTWIDTH = 8
) (
  input  logic                  SC_REGSHIFTEREXEC_CLOCK_50,
  input  logic                  SC_REGSHIFTEREXEC_RESET_InLow,
  input  logic                  SC_REGSHIFTEREXEC_clear_InLow,
  input  logic                  SC_REGSHIFTEREXEC_load_InLow,
  input  logic [1:0]            SC_REGSHIFTEREXEC_shiftselection_In,
  input  logic [DATAWIDTH-1:0]  SC_REGSHIFTEREXEC_data_InBUS,
  input  logic                  SC_REGSHIFTEREXEC_serial_In,
  output logic [DATAWIDTH-1:0]  SC_REGSHIFTEREXEC_data_OutBUS,
  output logic                  SC_REGSHIFTEREXEC_carry_Out,
  output logic                  SC_REGSHIFTEREXEC_zero_Out,
  output logic                  SC_REGSHIFTEREXEC_done_Out,
  output logic [COUNTWIDTH-1:0] SC_REGSHIFTEREXEC_opcount_OutBUS,
  output logic                  SC_REGSHIFTEREXEC_error_Out
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_RIGHT = 3'd3,
    OP_LEFT  = 3'd4,
    OP_RSVD  = 3'd5
  } op_t;

  localparam logic [1:0]            SEL_RIGHT = 2'b01;
  localparam logic [1:0]            SEL_LEFT  = 2'b10;
  localparam logic [1:0]            SEL_RSVD  = 2'b00;
  localparam logic [1:0]            SEL_IDLE  = 2'b11;
  localparam logic [COUNTWIDTH-1:0] CNT_ONE   = {{(COUNTWIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [DATAWIDTH-1:0]    data_r;
  logic                    carry_r;
  logic                    done_r;
  logic [COUNTWIDTH-1:0]   opcount_r;
  logic                    error_r;
  logic [3:0]              held_cmd_r;

  logic                    clear_act_s;
  logic                    load_act_s;
  logic                    shift_act_s;
  logic                    cmd_active_s;
  logic                    multi_cmd_s;
  logic [3:0]              cmd_vec_s;
  op_t                     op_s;
  logic                    exec_s;
  logic [DATAWIDTH-1:0]    data_nxt_s;
  logic                    carry_nxt_s;

  assign clear_act_s  = ~SC_REGSHIFTEREXEC_clear_InLow;
  assign load_act_s   = ~SC_REGSHIFTEREXEC_load_InLow;
  assign shift_act_s  = (SC_REGSHIFTEREXEC_shiftselection_In != SEL_IDLE);
  assign cmd_active_s = clear_act_s | load_act_s | shift_act_s;
  assign multi_cmd_s  = (clear_act_s & load_act_s) | (clear_act_s & shift_act_s)
                      | (load_act_s & shift_act_s);
  // Raw command pattern; a change while held in WAIT means a command was dropped.
  assign cmd_vec_s    = {SC_REGSHIFTEREXEC_clear_InLow, SC_REGSHIFTEREXEC_load_InLow,
                         SC_REGSHIFTEREXEC_shiftselection_In};

  // Priority decode: clear > load > shift right > shift left.
  always_comb begin
    op_s = OP_NONE;
    if (clear_act_s) begin
      op_s = OP_CLEAR;
    end else if (load_act_s) begin
      op_s = OP_LOAD;
    end else begin
      case (SC_REGSHIFTEREXEC_shiftselection_In)
        SEL_RIGHT: op_s = OP_RIGHT;
        SEL_LEFT:  op_s = OP_LEFT;
        SEL_RSVD:  op_s = OP_RSVD;
        default:   op_s = OP_NONE;
      endcase
    end
  end

  assign exec_s = (op_s == OP_CLEAR) || (op_s == OP_LOAD)
               || (op_s == OP_RIGHT) || (op_s == OP_LEFT);

  // Next register and carry value for the decoded operation.
  always_comb begin
    data_nxt_s  = data_r;
    carry_nxt_s = carry_r;
    case (op_s)
      OP_CLEAR: begin
        data_nxt_s  = '0;
        carry_nxt_s = 1'b0;
      end
      OP_LOAD: begin
        data_nxt_s  = SC_REGSHIFTEREXEC_data_InBUS;
        carry_nxt_s = carry_r;
      end
      OP_RIGHT: begin
        data_nxt_s  = {SC_REGSHIFTEREXEC_serial_In, data_r[DATAWIDTH-1:1]};
        carry_nxt_s = data_r[0];
      end
      OP_LEFT: begin
        data_nxt_s  = {data_r[DATAWIDTH-2:0], SC_REGSHIFTEREXEC_serial_In};
        carry_nxt_s = data_r[DATAWIDTH-1];
      end
      default: begin
        data_nxt_s  = data_r;
        carry_nxt_s = carry_r;
      end
    endcase
  end

  // Execution guard FSM with the datapath registers it controls.
  always_ff @(posedge SC_REGSHIFTEREXEC_CLOCK_50 or negedge SC_REGSHIFTEREXEC_RESET_InLow) begin
    if (!SC_REGSHIFTEREXEC_RESET_InLow) begin
      state_r    <= ST_IDLE;
      data_r     <= '0;
      carry_r    <= 1'b0;
      done_r     <= 1'b0;
      opcount_r  <= '0;
      error_r    <= 1'b0;
      held_cmd_r <= 4'hF;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_active_s) begin
            state_r    <= ST_WAIT;
            held_cmd_r <= cmd_vec_s;
            if (exec_s) begin
              data_r    <= data_nxt_s;
              carry_r   <= carry_nxt_s;
              opcount_r <= opcount_r + CNT_ONE;
              done_r    <= 1'b1;
            end
            if (multi_cmd_s || (op_s == OP_RSVD)) begin
              error_r <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!cmd_active_s) begin
            state_r <= ST_IDLE;
          end else begin
            if (cmd_vec_s != held_cmd_r) begin
              error_r <= 1'b1;
            end
            held_cmd_r <= cmd_vec_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign SC_REGSHIFTEREXEC_data_OutBUS    = data_r;
  assign SC_REGSHIFTEREXEC_carry_Out      = carry_r;
  assign SC_REGSHIFTEREXEC_zero_Out       = (data_r == '0);
  assign SC_REGSHIFTEREXEC_done_Out       = done_r;
  assign SC_REGSHIFTEREXEC_opcount_OutBUS = opcount_r;
  assign SC_REGSHIFTEREXEC_error_Out      = error_r;

endmodule

// File: tb/tb_sc_regshifter_exec.sv
// Scoreboard bench for sc_regshifter_exec: expected results are queued at stimulus
// time and popped by a monitor whenever done_Out is presented.
module tb_sc_regshifter_exec;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_n = 1'b1;
  logic       load_n = 1'b1;
  logic [1:0] sel = 2'b11;
  logic [7:0] din = 8'h00;
  logic       ser_in = 1'b0;
  logic [7:0] dout;
  logic       carry;
  logic       zero;
  logic       done;
  logic [7:0] opcount;
  logic       err;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  sc_regshifter_exec #(.DATAWIDTH(8), .COUNTWIDTH(8)) dut (
    .SC_REGSHIFTEREXEC_CLOCK_50          (clk),
    .SC_REGSHIFTEREXEC_RESET_InLow       (rst_n),
    .SC_REGSHIFTEREXEC_clear_InLow       (clear_n),
    .SC_REGSHIFTEREXEC_load_InLow        (load_n),
    .SC_REGSHIFTEREXEC_shiftselection_In (sel),
    .SC_REGSHIFTEREXEC_data_InBUS        (din),
    .SC_REGSHIFTEREXEC_serial_In         (ser_in),
    .SC_REGSHIFTEREXEC_data_OutBUS       (dout),
    .SC_REGSHIFTEREXEC_carry_Out         (carry),
    .SC_REGSHIFTEREXEC_zero_Out          (zero),
    .SC_REGSHIFTEREXEC_done_Out          (done),
    .SC_REGSHIFTEREXEC_opcount_OutBUS    (opcount),
    .SC_REGSHIFTEREXEC_error_Out         (err)
  );

  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done with data=%h cnt=%0d, required no done", dout, opcount);
      end else begin
        e = sb_q.pop_front();
        if ({dout, carry, opcount, err} !== e) begin
          errors++;
          $display("FAIL op_result: got data=%h carry=%b cnt=%0d err=%b, required data=%h carry=%b cnt=%0d err=%b",
                   dout, carry, opcount, err, e.data, e.carry, e.cnt, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic c, input logic [7:0] n, input logic e);
    exp_t x;
    x.data = d; x.carry = c; x.cnt = n; x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic apply(input logic c, input logic l, input logic [1:0] s,
                       input logic [7:0] d, input logic sr);
    clear_n = c; load_n = l; sel = s; din = d; ser_in = sr;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    clear_n = 1'b1; load_n = 1'b1; sel = 2'b11;
  endtask

  task automatic pulse(input logic c, input logic l, input logic [1:0] s,
                       input logic [7:0] d, input logic sr);
    apply(c, l, s, d, sr);
    step(1);
    go_idle();
    step(1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_data"}, 32'(dout), 32'h0);
    chk({tag, "_carry"}, 32'(carry), 32'h0);
    chk({tag, "_zero"}, 32'(zero), 32'h1);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_cnt"}, 32'(opcount), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    check_reset_state("reset");
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] kb;
    go_idle();
    do_reset();

    // Load A5, shift right with fill 1, shift left with fill 0.
    push(8'hA5, 1'b0, 8'd1, 1'b0);
    pulse(1'b1, 1'b0, 2'b11, 8'hA5, 1'b0);
    chk("zero_after_load", 32'(zero), 32'h0);
    chk("done_one_cycle", 32'(done), 32'h0);
    push(8'hD2, 1'b1, 8'd2, 1'b0);
    pulse(1'b1, 1'b1, 2'b01, 8'h00, 1'b1);
    push(8'hA4, 1'b1, 8'd3, 1'b0);
    pulse(1'b1, 1'b1, 2'b10, 8'h00, 1'b0);

    // Held load executes once.
    push(8'h3C, 1'b1, 8'd4, 1'b0);
    apply(1'b1, 1'b0, 2'b11, 8'h3C, 1'b0);
    step(10);
    go_idle();
    step(1);
    chk("held_load_cnt", 32'(opcount), 32'd4);
    chk("held_load_err", 32'(err), 32'h0);

    push(8'h00, 1'b0, 8'd5, 1'b0);
    pulse(1'b0, 1'b1, 2'b11, 8'h00, 1'b0);
    chk("zero_after_clear", 32'(zero), 32'h1);

    // Clear and load together: clear wins, error sticks.
    push(8'h00, 1'b0, 8'd6, 1'b1);
    pulse(1'b0, 1'b0, 2'b11, 8'hFF, 1'b0);
    push(8'h55, 1'b0, 8'd7, 1'b1);
    pulse(1'b1, 1'b0, 2'b11, 8'h55, 1'b0);
    chk("err_sticky", 32'(err), 32'h1);

    do_reset();

    // 255 loads then a shift wraps the counter.
    for (int k = 1; k <= 255; k++) begin
      kb = 8'(k);
      push(kb, 1'b0, kb, 1'b0);
      pulse(1'b1, 1'b0, 2'b11, kb, 1'b0);
    end
    push(8'h7F, 1'b1, 8'd0, 1'b0);
    pulse(1'b1, 1'b1, 2'b01, 8'h00, 1'b0);
    chk("cnt_wrap", 32'(opcount), 32'h0);

    // Reserved code: no change, error set.
    pulse(1'b1, 1'b1, 2'b00, 8'h00, 1'b1);
    chk("rsvd_data", 32'(dout), 32'h7F);
    chk("rsvd_carry", 32'(carry), 32'h1);
    chk("rsvd_cnt", 32'(opcount), 32'h0);
    chk("rsvd_err", 32'(err), 32'h1);

    do_reset();

    // Dropped command: held load turns into a shift without an idle gap.
    push(8'h11, 1'b0, 8'd1, 1'b0);
    apply(1'b1, 1'b0, 2'b11, 8'h11, 1'b0);
    step(3);
    apply(1'b1, 1'b1, 2'b01, 8'h11, 1'b1);
    step(3);
    go_idle();
    step(1);
    chk("drop_data", 32'(dout), 32'h11);
    chk("drop_cnt", 32'(opcount), 32'h1);
    chk("drop_err", 32'(err), 32'h1);

    do_reset();

    // Reset in the middle of a held shift; shift runs once after release.
    push(8'h81, 1'b0, 8'd1, 1'b0);
    pulse(1'b1, 1'b0, 2'b11, 8'h81, 1'b0);
    push(8'h03, 1'b1, 8'd2, 1'b0);
    apply(1'b1, 1'b1, 2'b10, 8'h00, 1'b1);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    step(1);
    rst_n = 1'b1;
    push(8'h01, 1'b0, 8'd1, 1'b0);
    step(4);
    chk("after_reset_cnt", 32'(opcount), 32'h1);
    go_idle();
    step(2);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_regshifter_exec.md
# sc_regshifter_exec

Datapath end of the register-shifter control interface: a parameterised data register that executes the active-low clear/load commands and the 2-bit shift-selection code produced by the control state machine. A two-state execution guard runs exactly one operation per command assertion, however long the command is held. The block also reports carry-out, zero status, operation count and protocol errors to the top level, and sits between the control state machine and the display/LED logic.

## Interface
- DATAWIDTH, 8, width of the data register and load bus (≥ 2)
- COUNTWIDTH, 8, width of the executed-operation counter
- SC_REGSHIFTEREXEC_CLOCK_50  input  1  system clock; all state changes on its rising edge
- SC_REGSHIFTEREXEC_RESET_InLow  input  1  reset, asynchronous assert, active-low
- SC_REGSHIFTEREXEC_clear_InLow  input  1  clear command, active-low
- SC_REGSHIFTEREXEC_load_InLow  input  1  load command, active-low
- SC_REGSHIFTEREXEC_shiftselection_In  input  2  shift command: 2'b11 idle, 2'b01 shift right, 2'b10 shift left, 2'b00 reserved
- SC_REGSHIFTEREXEC_data_InBUS  input  DATAWIDTH  parallel value for load
- SC_REGSHIFTEREXEC_serial_In  input  1  fill bit for shifts
- SC_REGSHIFTEREXEC_data_OutBUS  output  DATAWIDTH  register contents
- SC_REGSHIFTEREXEC_carry_Out  output  1  last bit shifted out
- SC_REGSHIFTEREXEC_zero_Out  output  1  combinational, high when data_OutBUS == 0
- SC_REGSHIFTEREXEC_done_Out  output  1  one-cycle pulse, cycle after an operation executes
- SC_REGSHIFTEREXEC_opcount_OutBUS  output  COUNTWIDTH  executed operations, modulo 2^COUNTWIDTH
- SC_REGSHIFTEREXEC_error_Out  output  1  sticky protocol-error flag

## Operation
- A command is "active" when clear_InLow = 0, load_InLow = 0, or shiftselection_In ≠ 2'b11.
- Execution guard FSM:
  - IDLE (reset state): on an active command, execute it at this edge and go to WAIT.
  - WAIT: execute nothing. Go to IDLE on the first edge where no command is active; otherwise stay.
- Priority when several commands are active in IDLE:
  - clear > load > shift right > shift left.
  - Only the highest-priority command executes; error is set at the same edge.
- Clear: data ← 0, carry ← 0.
- Load: data ← data_InBUS; carry unchanged.
- Shift right: data ← {serial_In, data[DATAWIDTH-1:1]}, carry ← data[0].
- Shift left: data ← {data[DATAWIDTH-2:0], serial_In}, carry ← data[DATAWIDTH-1].
- Reserved code 2'b00 with no clear/load active:
  - no data or carry change, no count, no done;
  - sets error; FSM goes to WAIT.
- Each executed operation increments opcount by 1 and wraps from all-ones to 0.
- A command that becomes active while in WAIT after an inactive gap of zero cycles is not executed, and sets error (dropped command). A continuously held command is not an error.
- error is cleared only by reset.

## Timing
- Reset values: data_OutBUS = 0, carry_Out = 0, zero_Out = 1, done_Out = 0, opcount = 0, error_Out = 0, FSM = IDLE.
- Reset assertion takes effect immediately, mid-operation included; deassertion is synchronous to the next edge.
- Latency: a command active at edge n (FSM in IDLE) gives new data, carry and opcount visible after edge n; done_Out is high for the cycle after edge n.
- A one-cycle command pulse followed by one inactive cycle returns the FSM to IDLE. Minimum command spacing is therefore 2 cycles: pulses at edges n and n+2 both execute.
- Dropped-command detection: the FSM is in WAIT, the command that caused entry has changed to a different active command with no inactive edge in between (e.g. a load held, then a shift appears).
- zero_Out tracks data_OutBUS combinationally, with no extra latency.

## Test plan
- Reset, then load 8'hA5 as a one-cycle pulse → data = A5, opcount = 1, done high for exactly one cycle, zero = 0, error = 0.
- From A5, shift right with serial_In = 1 → data = D2, carry = 1. Then shift left with serial_In = 0 (pulse spacing 2) → data = A4, carry = 1, opcount = 3.
- Load held low for 10 cycles with data_InBUS = 8'h3C → single execution, opcount +1 only, no error. Release, then a clear pulse → data = 0, zero = 1, carry = 0.
- Clear and load low in the same cycle with data_InBUS = FF → data = 00, error = 1, opcount +1. error stays 1 through later valid commands until reset.
- opcount preloaded by 255 load pulses, then one shift → opcount wraps to 0. shiftselection = 2'b00 pulse → no data change, opcount unchanged, error = 1.
- Reset asserted mid-sequence while a shift is held → all outputs return to reset values immediately; after release with the shift still held, the shift executes once at the first edge.
